// File: rtl/sextium_pkg.sv
// rtl/sextium_pkg.sv - shared Sextium definitions: bus widths, DMA FSM states, bus request encoding
// Purpose: common constants and types used by the DMA copy engine, its bus
//          interface, and any other initiator on the Sextium RAM port.
// Ports:   none (package).

package sextium_pkg;

  localparam int SEXTIUM_ADDR_W = 16;
  localparam int SEXTIUM_DATA_W = 16;

  // DMA copy FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  // Request kind on the RAM port, encoded as {mem_write, mem_read}
  typedef enum logic [1:0] {
    BUS_IDLE     = 2'b00,
    BUS_READ     = 2'b01,
    BUS_WRITE    = 2'b10,
    BUS_CONFLICT = 2'b11
  } bus_req_e;

  function automatic bus_req_e bus_req(input logic rd, input logic wr);
    return bus_req_e'({wr, rd});
  endfunction

endpackage

// File: rtl/sextium_dma_copy_if.sv
// rtl/sextium_dma_copy_if.sv - Sextium RAM request/acknowledge port
// Purpose: groups the shared RAM port used by the CPU and by the DMA engine.
// Ports:   addr_bus, mem_bus_out, mem_read, mem_write (initiator -> RAM);
//          mem_bus_in, mem_ack (RAM -> initiator).
//          master modport for an initiator, slave modport for the RAM side.

interface sextium_dma_copy_if
  import sextium_pkg::*;
#(
  parameter int ADDR_W = SEXTIUM_ADDR_W,
  parameter int DATA_W = SEXTIUM_DATA_W
);

  logic [ADDR_W-1:0] addr_bus;
  logic [DATA_W-1:0] mem_bus_out;
  logic [DATA_W-1:0] mem_bus_in;
  logic              mem_read;
  logic              mem_write;
  logic              mem_ack;

  modport master (
    output addr_bus, mem_bus_out, mem_read, mem_write,
    input  mem_bus_in, mem_ack
  );

  modport slave (
    input  addr_bus, mem_bus_out, mem_read, mem_write,
    output mem_bus_in, mem_ack
  );

endinterface

// File: rtl/sextium_dma_copy.sv
// rtl/sextium_dma_copy.sv - block-copy bus initiator for Sextium RAM
// Purpose: copies count words from src_addr upward to dst_addr upward, one
//          read then one write per word, through the shared RAM port.
// Ports:   clock; reset (asynchronous, active-low);
//          start, src_addr, dst_addr, count - copy request, sampled in idle;
//          abort - level, ends the copy after the current access;
//          busy, done, aborted - status;
//          mem - master side of the RAM request/acknowledge port.

module sextium_dma_copy
  import sextium_pkg::*;
#(
  parameter int ADDR_W = SEXTIUM_ADDR_W,
  parameter int DATA_W = SEXTIUM_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [15:0]       count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  sextium_dma_copy_if.master mem
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [15:0]       remaining;
  logic [DATA_W-1:0] data_buf;   // word in transit between its read and its write

  // Write data is the buffered word itself; it is only sampled while mem_write is high.
  assign mem.mem_bus_out = data_buf;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      remaining     <= '0;
      data_buf      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      mem.mem_read  <= 1'b0;
      mem.mem_write <= 1'b0;
      mem.addr_bus  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            rd_ptr    <= src_addr;
            wr_ptr    <= dst_addr;
            remaining <= count;
            aborted   <= 1'b0;
            busy      <= 1'b1;
            if (count == 16'd0) begin
              state <= ST_FIN;
            end else begin
              state        <= ST_RD;
              mem.mem_read <= 1'b1;
              mem.addr_bus <= src_addr;
            end
          end
        end
        ST_RD: begin
          if (mem.mem_ack) begin
            data_buf     <= mem.mem_bus_in;
            rd_ptr       <= rd_ptr + 1'b1;
            mem.mem_read <= 1'b0;
            if (abort) begin
              // the word just read is dropped, not written
              state <= ST_FIN;
            end else begin
              state         <= ST_WR;
              mem.mem_write <= 1'b1;
              mem.addr_bus  <= wr_ptr;
            end
          end
        end
        ST_WR: begin
          if (mem.mem_ack) begin
            wr_ptr        <= wr_ptr + 1'b1;
            remaining     <= remaining - 1'b1;
            mem.mem_write <= 1'b0;
            if (remaining == 16'd1 || abort) begin
              state <= ST_FIN;
            end else begin
              // rd_ptr already points at the next source word
              state        <= ST_RD;
              mem.mem_read <= 1'b1;
              mem.addr_bus <= rd_ptr;
            end
          end
        end
        ST_FIN: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          // words left over can only mean the copy was cut short
          aborted <= (remaining != 16'd0);
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sextium_dma_copy.sv
// tb/tb_sextium_dma_copy.sv - self-checking bench for sextium_dma_copy with RAM responder and access-sequence model

module tb_sextium_dma_copy;
  import sextium_pkg::*;

  typedef struct {
    bus_req_e    kind;
    logic [15:0] addr;
    logic [15:0] data;
  } acc_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] count;
  logic        abort;
  logic        busy;
  logic        done;
  logic        aborted;

  sextium_dma_copy_if #(.ADDR_W(16), .DATA_W(16)) mem ();

  sextium_dma_copy #(.ADDR_W(16), .DATA_W(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .count    (count),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .mem      (mem.master)
  );

  always #5 clock = ~clock;

  logic [15:0] ram   [0:65535];
  logic [15:0] model [0:65535];
  acc_t        exp_q [$];
  logic [15:0] rd_log [$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stretch = 0;
  int acc_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int exp_lat = 0;
  int last_lat = 0;
  bit done_seen = 0;
  bit expecting = 0;
  bit exp_aborted = 0;
  bit last_aborted = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] v);
    ram[a]   = v;
    model[a] = v;
  endtask

  task automatic cycle_counter();
    forever begin
      @(posedge clock);
      cyc++;
    end
  endtask

  // RAM controller: acks one cycle after it sees a request, plus `stretch` extra cycles
  task automatic responder();
    int wait_cnt = 0;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        mem.mem_ack <= 1'b0;
        wait_cnt = 0;
      end else if (mem.mem_ack) begin
        mem.mem_ack <= 1'b0;
      end else if (mem.mem_read || mem.mem_write) begin
        if (wait_cnt < stretch) begin
          wait_cnt++;
        end else begin
          wait_cnt = 0;
          mem.mem_ack <= 1'b1;
          if (mem.mem_read) mem.mem_bus_in <= ram[mem.addr_bus];
          else              ram[mem.addr_bus] <= mem.mem_bus_out;
        end
      end
    end
  endtask

  // Protocol checker and access-sequence compare, every cycle
  task automatic monitor();
    bus_req_e    cur;
    bus_req_e    prev_req = BUS_IDLE;
    logic [15:0] prev_addr = '0;
    logic [15:0] prev_data = '0;
    logic        prev_ack = 1'b0;
    acc_t        e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_req = BUS_IDLE;
        prev_ack = 1'b0;
        continue;
      end
      cur = bus_req(mem.mem_read, mem.mem_write);
      check("rd_wr_exclusive", {mem.mem_read & mem.mem_write}, 1'b0);
      if (prev_req != BUS_IDLE && !prev_ack)
        check("req_hold",
              {cur, mem.addr_bus, (cur == BUS_WRITE) ? mem.mem_bus_out : 16'h0},
              {prev_req, prev_addr, (prev_req == BUS_WRITE) ? prev_data : 16'h0});
      if (mem.mem_ack && cur != BUS_IDLE) begin
        acc_cnt++;
        if (cur == BUS_READ) rd_log.push_back(mem.addr_bus);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_access: got kind %0d addr %0h, expected no access", cur, mem.addr_bus);
        end else begin
          e = exp_q.pop_front();
          check("access_kind", cur, e.kind);
          check("access_addr", mem.addr_bus, e.addr);
          if (e.kind == BUS_WRITE) check("write_data", mem.mem_bus_out, e.data);
        end
      end
      if (done) begin
        if (!expecting) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected done=0");
        end else begin
          done_seen    = 1'b1;
          done_cyc     = cyc;
          last_aborted = aborted;
          check("busy_at_done", busy, 1'b0);
          check("aborted_at_done", aborted, exp_aborted);
        end
      end
      prev_req  = cur;
      prev_addr = mem.addr_bus;
      prev_data = mem.mem_bus_out;
      prev_ack  = mem.mem_ack;
    end
  endtask

  task automatic compare_ram();
    int bad = -1;
    for (int i = 0; i < 65536; i++)
      if (bad < 0 && ram[i] !== model[i]) bad = i;
    check("ram_image_first_bad_addr", bad, -1);
  endtask

  // Expected accesses: ascending read/write pairs, copy applied word by word
  // to the model so overlapping ranges behave as a real ascending copy.
  task automatic run_copy(input logic [15:0] src, input logic [15:0] dst, input int cnt,
                          input int abort_at, input int stretch_v, input bit extra);
    logic [15:0] a;
    logic [15:0] d;
    exp_q.delete();
    rd_log.delete();
    for (int i = 0; i < cnt; i++) begin
      a = 16'(src + i);
      exp_q.push_back('{BUS_READ, a, 16'h0000});
      if (i == abort_at) break;
      d = model[a];
      exp_q.push_back('{BUS_WRITE, 16'(dst + i), d});
      model[16'(dst + i)] = d;
    end
    exp_aborted = (abort_at >= 0) && (abort_at < cnt);
    exp_lat     = 2 + 2 * exp_q.size();
    stretch     = stretch_v;
    acc_cnt     = 0;
    done_seen   = 1'b0;
    expecting   = 1'b1;
    @(negedge clock); #1;
    start = 1'b1; src_addr = src; dst_addr = dst; count = 16'(cnt);
    start_cyc = cyc;
    @(negedge clock); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("req_after_start", {mem.mem_read, mem.mem_write}, (cnt != 0) ? 2'b10 : 2'b00);
    if (cnt != 0) check("first_read_addr", mem.addr_bus, src);
    for (int k = 0; k < 3000 && !done_seen; k++) begin
      start = extra && (k == 2);
      if (start) begin
        src_addr = 16'($urandom);
        dst_addr = 16'($urandom);
        count    = 16'($urandom_range(1, 5));
      end
      if (exp_aborted && mem.mem_read && acc_cnt == 2 * abort_at) abort = 1'b1;
      @(negedge clock); #1;
    end
    start = 1'b0;
    abort = 1'b0;
    if (!done_seen) begin
      checks++;
      errors++;
      last_lat = -1;
      $display("FAIL done_timeout: got no done within 3000 cycles, expected done");
    end else begin
      last_lat = done_cyc - start_cyc;
      if (stretch_v == 0) check("done_latency", last_lat, exp_lat);
    end
    expecting = 1'b0;
    check("accesses_left", exp_q.size(), 0);
    @(negedge clock); #1;
    check("done_one_cycle", done, 1'b0);
    check("aborted_held", aborted, exp_aborted);
    compare_ram();
  endtask

  initial begin
    logic [63:0] rl;
    logic [15:0] s, d;
    int c, ab;
    start = 1'b0; src_addr = '0; dst_addr = '0; count = '0; abort = 1'b0;
    mem.mem_ack = 1'b0; mem.mem_bus_in = '0;
    for (int i = 0; i < 65536; i++) poke(16'(i), 16'($urandom));
    fork
      cycle_counter();
      responder();
      monitor();
    join_none

    #2 reset = 1'b0;
    #1;
    check("reset_outputs", {busy, done, aborted, mem.mem_read, mem.mem_write, mem.addr_bus, mem.mem_bus_out}, '0);
    @(negedge clock); #1;
    reset = 1'b1;
    @(negedge clock); #1;
    check("idle_outputs", {busy, done, aborted, mem.mem_read, mem.mem_write}, '0);

    // basic copy, with a second start while busy
    poke(16'h0010, 16'h00A1); poke(16'h0011, 16'h00B2);
    poke(16'h0012, 16'h00C3); poke(16'h0013, 16'h00D4);
    run_copy(16'h0010, 16'h0100, 4, -1, 0, 1'b1);
    check("basic_dst_words", {ram[16'h0100], ram[16'h0101], ram[16'h0102], ram[16'h0103]}, 64'h00A1_00B2_00C3_00D4);
    check("basic_latency", last_lat, 18);

    // zero count
    run_copy(16'h0010, 16'h0300, 0, -1, 0, 1'b0);
    check("zero_latency", last_lat, 2);
    check("zero_no_access", acc_cnt, 0);

    // address wrap-around
    poke(16'hFFFE, 16'h5A01); poke(16'hFFFF, 16'h5A02);
    poke(16'h0000, 16'h5A03); poke(16'h0001, 16'h5A04);
    run_copy(16'hFFFE, 16'h0200, 4, -1, 0, 1'b0);
    rl = (rd_log.size() == 4) ? {rd_log[0], rd_log[1], rd_log[2], rd_log[3]} : 64'h0;
    check("wrap_read_addrs", rl, 64'hFFFE_FFFF_0000_0001);
    check("wrap_dst_words", {ram[16'h0200], ram[16'h0201], ram[16'h0202], ram[16'h0203]}, 64'h5A01_5A02_5A03_5A04);

    // abort during the read of word 3 of 8
    for (int i = 0; i < 8; i++) begin
      poke(16'(16'h0400 + i), 16'(16'h1000 + i));
      poke(16'(16'h0500 + i), 16'hDEAD);
    end
    run_copy(16'h0400, 16'h0500, 8, 2, 0, 1'b0);
    check("abort_dst_words", {ram[16'h0500], ram[16'h0501], ram[16'h0502], ram[16'h0507]}, 64'h1000_1001_DEAD_DEAD);
    check("abort_flag", last_aborted, 1'b1);
    check("abort_latency", last_lat, 12);

    // reset in the middle of the first write
    exp_q.delete();
    exp_q.push_back('{BUS_READ, 16'h0600, 16'h0000});
    stretch = 0;
    @(negedge clock); #1;
    start = 1'b1; src_addr = 16'h0600; dst_addr = 16'h0700; count = 16'd3;
    @(negedge clock); #1;
    start = 1'b0;
    for (int k = 0; k < 50 && !mem.mem_write; k++) begin
      @(negedge clock); #1;
    end
    check("reached_write", mem.mem_write, 1'b1);
    reset = 1'b0;
    #1;
    check("midcopy_reset_outputs", {busy, done, aborted, mem.mem_read, mem.mem_write, mem.addr_bus, mem.mem_bus_out}, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); #1;
      check("reset_held_quiet", {busy, done, mem.mem_read, mem.mem_write}, '0);
    end
    reset = 1'b1;
    check("reset_accesses_left", exp_q.size(), 0);
    run_copy(16'h0610, 16'h0710, 1, -1, 0, 1'b0);
    check("post_reset_latency", last_lat, 6);

    // randomized copies: overlapping ranges, aborts, stretched acks, ignored starts
    for (int r = 0; r < 12; r++) begin
      s = 16'(16'h0800 + $urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) d = 16'(int'(s) + int'($urandom_range(0, 16)) - 8);
      else d = 16'($urandom);
      c  = int'($urandom_range(0, 10));
      ab = (c > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, c - 1)) : -1;
      run_copy(s, d, c, ab, int'($urandom_range(0, 2)), c >= 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
